// File: rtl/tracking_state_pkg.sv
`default_nettype none
// tracking_state_pkg: state-buffer address map and field layout shared by dump and load paths.
// Rev 1.0
package tracking_state_pkg;

  localparam logic [4:0] STATE_ADDR_PRN_STATE     = 5'd6;
  localparam logic [4:0] STATE_ADDR_PRN_COUNT     = 5'd7;
  localparam logic [4:0] STATE_ADDR_CARRIER_PHASE = 5'd8;
  localparam logic [4:0] STATE_ADDR_CARRIER_COUNT = 5'd9;
  localparam logic [4:0] STATE_ADDR_CODE_PHASE    = 5'd10;
  localparam logic [4:0] STATE_ADDR_CODE_COUNTS   = 5'd11;
  localparam logic [4:0] STATE_ADDR_COR_STATE     = 5'd12;
  localparam logic [4:0] STATE_ADDR_DECODE_DATA   = 5'd13;
  localparam logic [4:0] STATE_ADDR_PRN2_STATE    = 5'd15;
  localparam logic [4:0] STATE_ADDR_IQ_ACC        = 5'd16;

  localparam int STATE_WORD_COUNT        = 10;
  localparam int STATE_WORD_COUNT_NO_ACC = 9;

  // cor_state word layout
  localparam int COR_STATE_ENABLE_BIT       = 0;
  localparam int COR_STATE_CARRIER_LOCK_BIT = 1;
  localparam int COR_STATE_CODE_LOCK_BIT    = 2;
  localparam int COR_STATE_MS_COUNT_LSB     = 8;
  localparam int COR_STATE_MS_COUNT_MSB     = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } load_fsm_e;

  // Word index -> state address; address 14 is skipped.
  function automatic logic [4:0] state_word_addr(input logic [3:0] idx);
    logic [4:0] a;
    case (idx)
      4'd0:    a = STATE_ADDR_PRN_STATE;
      4'd1:    a = STATE_ADDR_PRN_COUNT;
      4'd2:    a = STATE_ADDR_CARRIER_PHASE;
      4'd3:    a = STATE_ADDR_CARRIER_COUNT;
      4'd4:    a = STATE_ADDR_CODE_PHASE;
      4'd5:    a = STATE_ADDR_CODE_COUNTS;
      4'd6:    a = STATE_ADDR_COR_STATE;
      4'd7:    a = STATE_ADDR_DECODE_DATA;
      4'd8:    a = STATE_ADDR_PRN2_STATE;
      default: a = STATE_ADDR_IQ_ACC;
    endcase
    return a;
  endfunction

endpackage
`default_nettype wire

// File: rtl/state_load_pipe.sv
`default_nettype none
// state_load_pipe: RD_LATENCY-deep {valid, addr} tag delay line aligned with state-buffer read data.
// Rev 1.0
module state_load_pipe #(
  parameter int RD_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       flush_i,
  input  logic       in_valid_i,
  input  logic [4:0] in_addr_i,
  output logic       out_valid_o,
  output logic [4:0] out_addr_o,
  output logic       empty_o
);

  logic [RD_LATENCY-1:0]      vld_q;
  logic [RD_LATENCY-1:0][4:0] addr_q;

  // A flush drops every tag in flight, including one offered this cycle.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      vld_q  <= '0;
      addr_q <= '0;
    end else if (flush_i) begin
      vld_q  <= '0;
    end else begin
      vld_q[0]  <= in_valid_i;
      addr_q[0] <= in_addr_i;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  assign out_valid_o = vld_q[RD_LATENCY-1];
  assign out_addr_o  = addr_q[RD_LATENCY-1];
  assign empty_o     = ~|vld_q;

endmodule
`default_nettype wire

// File: rtl/load_state.sv
`default_nettype none
// load_state: restores one logical channel's saved state words into a physical correlator channel.
// Rev 1.0
module load_state
  import tracking_state_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter bit LOAD_ACC   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        load_start,
  input  logic        load_abort,
  input  logic [1:0]  physical_channel_index,
  output logic        load_busy,
  output logic        load_done,
  output logic        state_rd,
  output logic [4:0]  state_addr,
  input  logic        state_rd_gnt,
  input  logic [31:0] state_d4rd,
  output logic [3:0]  load_en,
  output logic [4:0]  load_addr,
  output logic [31:0] load_data
);

  localparam logic [3:0] LAST_IDX = LOAD_ACC ? 4'(STATE_WORD_COUNT - 1)
                                             : 4'(STATE_WORD_COUNT_NO_ACC - 1);

  load_fsm_e   state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [1:0]  chan_q, chan_d;
  logic [3:0]  load_en_q, load_en_d;
  logic [4:0]  load_addr_q, load_addr_d;
  logic [31:0] load_data_q, load_data_d;

  logic       w_grant;
  logic       w_abort;
  logic       w_tag_valid;
  logic [4:0] w_tag_addr;
  logic       w_pipe_empty;

  assign w_grant = state_rd & state_rd_gnt;
  assign w_abort = load_abort & (state_q != ST_IDLE);

  state_load_pipe #(
    .RD_LATENCY (RD_LATENCY)
  ) u_pipe (
    .clk         (clk),
    .rst_b       (rst_b),
    .flush_i     (w_abort),
    .in_valid_i  (w_grant),
    .in_addr_i   (state_addr),
    .out_valid_o (w_tag_valid),
    .out_addr_o  (w_tag_addr),
    .empty_o     (w_pipe_empty)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      chan_q      <= '0;
      load_en_q   <= '0;
      load_addr_q <= '0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      chan_q      <= chan_d;
      load_en_q   <= load_en_d;
      load_addr_q <= load_addr_d;
      load_data_q <= load_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    chan_d  = chan_q;
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d = ST_REQ;
          idx_d   = '0;
          chan_d  = physical_channel_index;
        end
      end
      ST_REQ: begin
        if (state_rd_gnt) begin
          if (idx_q == LAST_IDX) state_d = ST_DRAIN;
          else                   idx_d   = idx_q + 4'd1;
        end
      end
      // Empty pipe means the last tag has already been turned into a load.
      ST_DRAIN: if (w_pipe_empty) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (w_abort) state_d = ST_IDLE;
  end

  always_comb begin
    load_busy  = 1'b0;
    load_done  = 1'b0;
    state_rd   = 1'b0;
    state_addr = '0;
    case (state_q)
      ST_REQ: begin
        load_busy  = 1'b1;
        state_rd   = 1'b1;
        state_addr = state_word_addr(idx_q);
      end
      ST_DRAIN: load_busy = 1'b1;
      ST_DONE:  load_done = 1'b1;
      default:  ;
    endcase
  end

  always_comb begin
    load_en_d   = '0;
    load_addr_d = load_addr_q;
    load_data_d = load_data_q;
    if (w_tag_valid && !w_abort) begin
      load_en_d   = 4'b0001 << chan_q;
      load_addr_d = w_tag_addr;
      load_data_d = state_d4rd;
    end
  end

  assign load_en   = load_en_q;
  assign load_addr = load_addr_q;
  assign load_data = load_data_q;

endmodule
`default_nettype wire

// File: tb/tb_load_state.sv
`default_nettype none
// tb_load_state: directed table, corner sequences and random traffic against a transaction-level model.
// Rev 1.0
module tb_load_state;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        load_start = 1'b0;
  logic        load_abort = 1'b0;
  logic [1:0]  physical_channel_index = 2'd0;
  logic        state_rd_gnt = 1'b0;
  logic [31:0] state_d4rd = 32'd0;

  logic        a_busy, a_done, a_rd, b_busy, b_done, b_rd;
  logic [4:0]  a_addr, a_laddr, b_addr, b_laddr;
  logic [3:0]  a_en, b_en;
  logic [31:0] a_ldata, b_ldata;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  load_state #(.RD_LATENCY(1), .LOAD_ACC(1'b1)) u_dut_a (
    .clk(clk), .rst_b(rst_b), .load_start(load_start), .load_abort(load_abort),
    .physical_channel_index(physical_channel_index), .load_busy(a_busy), .load_done(a_done),
    .state_rd(a_rd), .state_addr(a_addr), .state_rd_gnt(state_rd_gnt), .state_d4rd(state_d4rd),
    .load_en(a_en), .load_addr(a_laddr), .load_data(a_ldata));

  load_state #(.RD_LATENCY(3), .LOAD_ACC(1'b0)) u_dut_b (
    .clk(clk), .rst_b(rst_b), .load_start(load_start), .load_abort(load_abort),
    .physical_channel_index(physical_channel_index), .load_busy(b_busy), .load_done(b_done),
    .state_rd(b_rd), .state_addr(b_addr), .state_rd_gnt(state_rd_gnt), .state_d4rd(state_d4rd),
    .load_en(b_en), .load_addr(b_laddr), .load_data(b_ldata));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model: requests become loads L+1 cycles later ----------------
  logic [4:0] seq_tbl [10] = '{5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd15, 5'd16};

  typedef struct { int inst; int due; logic [4:0] addr; int src; } pend_t;
  pend_t pq[$];

  logic [31:0] hist [256];
  int          ph [2];     // 0 idle, 1 requesting, 2 waiting for last load, 3 done pulse
  int          widx [2];
  logic [1:0]  chan [2];
  logic [4:0]  m_laddr [2];
  logic [31:0] m_ldata [2];
  logic [3:0]  m_en;
  int          lat, nw, npend;
  logic        abort_k;

  always @(negedge clk) begin
    hist[cyc % 256] = state_d4rd;
    for (int k = 0; k < 2; k++) begin
      lat = (k == 1) ? 3 : 1;
      nw  = (k == 1) ? 9 : 10;
      if (!rst_b) begin
        ph[k] = 0; widx[k] = 0; chan[k] = 2'd0; m_laddr[k] = 5'd0; m_ldata[k] = 32'd0;
        for (int i = pq.size() - 1; i >= 0; i--) if (pq[i].inst == k) pq.delete(i);
      end
      m_en = 4'd0;
      foreach (pq[i]) if (pq[i].inst == k && pq[i].due == cyc) begin
        m_en       = 4'b0001 << chan[k];
        m_laddr[k] = pq[i].addr;
        m_ldata[k] = hist[pq[i].src % 256];
      end
      chk(k ? "b.state_rd"  : "a.state_rd",   k ? b_rd    : a_rd,    ph[k] == 1);
      chk(k ? "b.state_addr": "a.state_addr", k ? b_addr  : a_addr,  (ph[k] == 1) ? seq_tbl[widx[k]] : 5'd0);
      chk(k ? "b.load_busy" : "a.load_busy",  k ? b_busy  : a_busy,  ph[k] == 1 || ph[k] == 2);
      chk(k ? "b.load_done" : "a.load_done",  k ? b_done  : a_done,  ph[k] == 3);
      chk(k ? "b.load_en"   : "a.load_en",    k ? b_en    : a_en,    m_en);
      chk(k ? "b.load_addr" : "a.load_addr",  k ? b_laddr : a_laddr, m_laddr[k]);
      chk(k ? "b.load_data" : "a.load_data",  k ? b_ldata : a_ldata, m_ldata[k]);
      if (rst_b) begin
        abort_k = load_abort && ph[k] != 0;
        for (int i = pq.size() - 1; i >= 0; i--)
          if (pq[i].inst == k && (abort_k || pq[i].due <= cyc)) pq.delete(i);
        npend = 0;
        foreach (pq[i]) if (pq[i].inst == k) npend++;
        if (abort_k) ph[k] = 0;
        else case (ph[k])
          0: if (load_start) begin ph[k] = 1; widx[k] = 0; chan[k] = physical_channel_index; end
          1: if (state_rd_gnt) begin
               pq.push_back('{k, cyc + lat + 1, seq_tbl[widx[k]], cyc + lat});
               if (widx[k] == nw - 1) ph[k] = 2; else widx[k]++;
             end
          2: if (npend == 0) ph[k] = 3;
          default: ph[k] = 0;
        endcase
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic st, input logic ab, input logic gn, input logic [1:0] pc);
    @(posedge clk); #1;
    load_start = st; load_abort = ab; state_rd_gnt = gn; physical_channel_index = pc;
    state_d4rd = $urandom;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 2'($urandom_range(3)));
  endtask

  typedef struct { logic st; logic rd; logic [4:0] addr; logic [3:0] en;
                   logic [4:0] laddr; logic busy; logic done; } vec_t;
  vec_t vt [15];
  int   cnt_a, cnt_b, bad_a;

  initial begin
    // Full load, channel 2, grant held high, on the RD_LATENCY=1 / LOAD_ACC=1 instance
    for (int i = 0; i < 15; i++) begin
      vt[i].st    = (i == 0);
      vt[i].rd    = (i >= 1 && i <= 10);
      vt[i].addr  = vt[i].rd ? seq_tbl[(i >= 1 && i <= 10) ? i - 1 : 0] : 5'd0;
      vt[i].en    = (i >= 3 && i <= 12) ? 4'b0100 : 4'b0000;
      vt[i].laddr = (i < 3) ? 5'd0 : (i <= 12) ? seq_tbl[(i >= 3 && i <= 12) ? i - 3 : 0] : 5'd16;
      vt[i].busy  = (i >= 1 && i <= 12);
      vt[i].done  = (i == 13);
    end

    repeat (3) @(posedge clk);
    #1 rst_b = 1'b1;

    for (int i = 0; i < 15; i++) begin
      step(vt[i].st, 1'b0, 1'b1, 2'd2);
      @(negedge clk);
      chk("tbl.state_rd",   a_rd,    vt[i].rd);
      chk("tbl.state_addr", a_addr,  vt[i].addr);
      chk("tbl.load_en",    a_en,    vt[i].en);
      chk("tbl.load_addr",  a_laddr, vt[i].laddr);
      chk("tbl.load_busy",  a_busy,  vt[i].busy);
      chk("tbl.load_done",  a_done,  vt[i].done);
    end
    idle(6);

    // Grant withheld in cycles 3-4
    for (int j = 0; j < 20; j++) begin
      step(j == 0, 1'b0, !(j == 3 || j == 4), 2'd0);
      @(negedge clk);
      if (j == 3 || j == 4) begin
        chk("stall.addr_hold", a_addr, 5'd8);
        chk("stall.rd_hold",   a_rd,   1'b1);
      end
      if (j == 13) chk("stall.no_early_done", a_done, 1'b0);
      if (j == 15) chk("stall.done_late",     a_done, 1'b1);
    end
    idle(4);

    // Abort two cycles after the first grant, then restart
    for (int j = 0; j < 30; j++) begin
      step(j == 0 || j == 8, j == 3, 1'b1, 2'd3);
      @(negedge clk);
      if (j == 4) begin
        chk("abort.rd",   a_rd,   1'b0);
        chk("abort.en",   a_en,   4'd0);
        chk("abort.busy", a_busy, 1'b0);
        chk("abort.b_rd", b_rd,   1'b0);
      end
      if (j == 9) chk("abort.restart_busy", a_busy, 1'b1);
    end
    idle(4);

    // Restart attempts while busy, channel index toggling, start on the done cycle
    cnt_a = 0; cnt_b = 0; bad_a = 0;
    for (int j = 0; j < 22; j++) begin
      step(j == 0 || (j % 3 == 1 && j <= 13), 1'b0, 1'b1, (j == 0) ? 2'd1 : 2'($urandom_range(3)));
      @(negedge clk);
      if (a_en == 4'b0010) cnt_a++; else if (a_en != 4'd0) bad_a++;
      if (b_en == 4'b0010) cnt_b++;
      if (j == 14) chk("busy.start_on_done_ignored", a_busy, 1'b0);
    end
    chk("busy.a_loads_on_ch1", cnt_a, 10);
    chk("busy.a_other_ch",     bad_a, 0);
    chk("busy.b_loads_on_ch1", cnt_b, 9);

    // Asynchronous reset in the middle of the request phase
    for (int j = 0; j < 4; j++) step(j == 0, 1'b0, 1'b1, 2'd1);
    @(posedge clk); #2;
    rst_b = 1'b0;
    #1;
    chk("rst.a_rd",   a_rd,   1'b0);
    chk("rst.a_busy", a_busy, 1'b0);
    chk("rst.a_en",   a_en,   4'd0);
    chk("rst.a_addr", a_addr, 5'd0);
    chk("rst.b_busy", b_busy, 1'b0);
    @(posedge clk); #1 rst_b = 1'b1;
    cnt_a = 0;
    for (int j = 0; j < 20; j++) begin
      step(j == 0, 1'b0, 1'b1, 2'd0);
      @(negedge clk);
      if (a_done) cnt_a++;
      if (j == 13) chk("rst.clean_done", a_done, 1'b1);
    end
    chk("rst.one_done", cnt_a, 1);

    // Random traffic
    for (int j = 0; j < 3000; j++)
      step($urandom_range(7) == 0, $urandom_range(39) == 0, $urandom_range(3) != 0,
           2'($urandom_range(3)));
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
